input_controller: RTL and testbench
===================================

INPUT_CONTROLLER -- requirements
Module: input_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 15000000, cycles from the first pulse of a held repeatable button to its first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 5000000, cycles between successive auto-repeat pulses.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port btn_in, input, 4, raw active-high buttons, asynchronous to clk; bit0 left, bit1 right, bit2 start/rotate, bit3 down.
REQ-007 Port controller_out, output, 4, registered one-cycle command pulses, same bit mapping as btn_in; feeds Grid_Controller controller_in.

Function
REQ-008 Each btn_in bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-009 Each bit SHALL have a debounced level db and a debounce counter wide enough for DEBOUNCE_CYCLES.
REQ-010 Counter behaviour: s2 == db clears the counter; s2 != db increments it; the increment that reaches DEBOUNCE_CYCLES sets db <= s2 and clears the counter in the same edge.
REQ-011 A glitch shorter than DEBOUNCE_CYCLES sampled cycles SHALL produce no db change and no pulse.
REQ-012 Each bit SHALL have a 3-state FSM: IDLE, DELAY, REPEAT, plus a repeat counter wide enough for max(REPEAT_DELAY, REPEAT_RATE).
REQ-013 IDLE: on the cycle db rises, raise a request for that bit, clear the repeat counter, go to DELAY; otherwise stay.
REQ-014 DELAY: db low -> IDLE, counter cleared, no request; counter reaching REPEAT_DELAY-1 on a repeatable bit (0, 1, 3) -> request, counter cleared, go to REPEAT; else increment.
REQ-015 REPEAT: db low -> IDLE; counter reaching REPEAT_RATE-1 -> request, counter cleared, stay; else increment.
REQ-016 Bit 2 (start/rotate) SHALL never auto-repeat: it stays in DELAY until db falls, then returns to IDLE.
REQ-017 Arbitration: controller_out SHALL be one-hot or zero; with simultaneous requests, priority is bit2 > bit3 > bit0 > bit1.
REQ-018 Losing requests SHALL be dropped, not queued; their FSMs advance exactly as if they had won.
REQ-019 Latency: with btn_in high from before edge k (first edge at which s1 samples 1) and held, controller_out bit goes high at edge k+DEBOUNCE_CYCLES+2 and low at the following edge.
REQ-020 Every pulse SHALL last exactly one cycle; controller_out SHALL never be high for two consecutive cycles on the same bit.
REQ-021 A release shorter than DEBOUNCE_CYCLES during DELAY or REPEAT SHALL not reset the FSM or the repeat counter.
REQ-022 A button pressed during another button's REPEAT SHALL run its own independent FSM; both may emit, subject to REQ-017.
REQ-023 Counters SHALL saturate-free wrap never occurs: each counter is cleared before exceeding its terminal value.

Reset
REQ-024 reset high at a rising edge SHALL clear s1, s2, db, all counters and controller_out to 0 and force every FSM to IDLE, overriding all other updates in that edge.
REQ-025 Mid-operation reset SHALL drop any in-flight pulse; a button still held after reset deasserts SHALL debounce afresh and emit a new first pulse per REQ-019.
REQ-026 controller_out SHALL be 4'b0000 during reset and in the first cycle after it.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-027 btn_in=0001 from before edge 10, held -> controller_out=0001 after edge 16 only; repeats after edges 26, 29, 32, ...
REQ-028 btn_in=0100 held 40 cycles -> exactly one 0100 pulse, no repeats; release then re-press -> one new pulse.
REQ-029 btn_in bit0 high for 3 cycles then low -> controller_out stays 0000.
REQ-030 btn_in=1101 rising together -> single 0100 pulse; 1000 repeats then win over bit0 on coinciding cycles; bit0 repeats appear only on non-coinciding cycles.
REQ-031 bit3 held into REPEAT, reset pulsed 1 cycle, bit3 still held -> no pulse for 6 cycles after reset, then a first pulse and full REPEAT_DELAY before repeating.
REQ-032 bit1 held in REPEAT with a 2-cycle low glitch -> repeat cadence unchanged.

Source files
------------

// File: rtl/input_controller.sv
// Four-button front end: synchronise, debounce, edge/auto-repeat FSM per button,
// then a fixed-priority pick that emits at most one registered one-cycle command pulse.
module input_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_in,
    output logic [3:0] controller_out
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [3:0] s1_reg;
    logic [3:0] s2_reg;
    logic [3:0] req;
    logic [3:0] grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= btn_in;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            // Start/rotate (bit 2) fires once per press and never auto-repeats.
            localparam bit REPEATABLE = (gi != 2);

            logic            db_reg;
            logic [DB_W-1:0] db_cnt_reg;
            state_t          state_reg;
            logic [RP_W-1:0] rp_cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    db_reg     <= 1'b0;
                    db_cnt_reg <= '0;
                end else if (s2_reg[gi] == db_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    db_reg     <= s2_reg[gi];
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end

            // IDLE with db high can only mean db has just risen.
            assign req[gi] = db_reg &&
                ((state_reg == IDLE) ||
                 (state_reg == DELAY && REPEATABLE && rp_cnt_reg == DELAY_LAST) ||
                 (state_reg == REPEAT && rp_cnt_reg == RATE_LAST));

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg  <= IDLE;
                    rp_cnt_reg <= '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            rp_cnt_reg <= '0;
                            if (db_reg) state_reg <= DELAY;
                        end
                        DELAY: begin
                            if (!db_reg) begin
                                state_reg  <= IDLE;
                                rp_cnt_reg <= '0;
                            end else if (rp_cnt_reg == DELAY_LAST) begin
                                // Non-repeatable bit parks here until release.
                                if (REPEATABLE) begin
                                    state_reg  <= REPEAT;
                                    rp_cnt_reg <= '0;
                                end
                            end else begin
                                rp_cnt_reg <= rp_cnt_reg + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (!db_reg) begin
                                state_reg  <= IDLE;
                                rp_cnt_reg <= '0;
                            end else if (rp_cnt_reg == RATE_LAST) begin
                                rp_cnt_reg <= '0;
                            end else begin
                                rp_cnt_reg <= rp_cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg  <= IDLE;
                            rp_cnt_reg <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Losers are simply dropped; their FSMs have already advanced above.
    always_comb begin
        grant = 4'b0000;
        if (req[2])      grant = 4'b0100;
        else if (req[3]) grant = 4'b1000;
        else if (req[0]) grant = 4'b0001;
        else if (req[1]) grant = 4'b0010;
    end

    always_ff @(posedge clk) begin
        if (reset) controller_out <= 4'b0000;
        else       controller_out <= grant;
    end

endmodule

// File: tb/tb_input_controller.sv
// Randomised and directed bench for input_controller with a press-age reference model.
module tb_input_controller;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_in = 4'b0000;
    logic [3:0] controller_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    input_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .controller_out(controller_out)
    );

    always #5 clk = ~clk;

    // Reference model: db flips after DEB consecutive differing synchronised samples;
    // a request fires at press age 0 and, for repeatable bits, at RD, RD+RR, RD+2RR, ...
    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    logic [3:0] m_db = '0;
    logic [3:0] m_hist [DEB-1] = '{default: 4'b0000};
    int         m_age [4] = '{default: 0};
    logic [3:0] m_held = '0;
    logic [3:0] exp_out = '0;

    always @(posedge clk) begin : model
        logic [3:0] req;
        logic [3:0] flip;
        int age_now;
        cyc <= cyc + 1;
        if (reset) begin
            m_s1 <= '0;
            m_s2 <= '0;
            m_db <= '0;
            m_held <= '0;
            exp_out <= '0;
            for (int j = 0; j < DEB - 1; j++) m_hist[j] <= '0;
            for (int b = 0; b < 4; b++) m_age[b] <= 0;
        end else begin
            req = '0;
            flip = '0;
            for (int b = 0; b < 4; b++) begin
                flip[b] = (m_s2[b] != m_db[b]);
                for (int j = 0; j < DEB - 1; j++)
                    if (m_hist[j][b] == m_db[b]) flip[b] = 1'b0;
                if (m_db[b]) begin
                    age_now = m_held[b] ? m_age[b] + 1 : 0;
                    if (age_now == 0 || (b != 2 && age_now >= RD && (age_now - RD) % RR == 0))
                        req[b] = 1'b1;
                    m_age[b] <= age_now;
                end
            end
            m_held <= m_db;
            m_db <= m_db ^ flip;
            m_hist[0] <= m_s2;
            for (int j = 1; j < DEB - 1; j++) m_hist[j] <= m_hist[j-1];
            m_s2 <= m_s1;
            m_s1 <= btn_in;
            exp_out <= req[2] ? 4'b0100 : req[3] ? 4'b1000 : req[0] ? 4'b0001 :
                       req[1] ? 4'b0010 : 4'b0000;
        end
    end

    always @(negedge clk)
        if (controller_out != 4'b0000) $display("cycle %0d pulse %b", cyc, controller_out);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce;
        btn_in = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        btn_in = 4'b1111;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (controller_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_hold got %b want 0000", controller_out);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (controller_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_first_cycle got %b want 0000", controller_out);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL reset_release i=%0d got %b want %b", i, controller_out, exp_out);
            end
        end
    endtask

    task automatic test_repeat_bit0;
        logic [3:0] want;
        quiesce();
        btn_in = 4'b0001;
        for (int i = 0; i < 28; i++) begin
            tick();
            want = (i == DEB + 2 || (i >= DEB + 2 + RD && (i - DEB - 2 - RD) % RR == 0))
                   ? 4'b0001 : 4'b0000;
            vectors++;
            if (controller_out !== want || controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL repeat_bit0 i=%0d got %b want %b model %b", i, controller_out, want, exp_out);
            end
        end
        btn_in = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL repeat_bit0_release i=%0d got %b want %b", i, controller_out, exp_out);
            end
        end
    endtask

    task automatic test_start_no_repeat;
        int pulses;
        quiesce();
        pulses = 0;
        btn_in = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (controller_out == 4'b0100) pulses++;
            vectors++;
            if (controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL start_hold i=%0d got %b want %b", i, controller_out, exp_out);
            end
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL start_pulse_count got %0d want 1", pulses);
        end
        btn_in = 4'b0000;
        for (int i = 0; i < 10; i++) tick();
        pulses = 0;
        btn_in = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (controller_out == 4'b0100) pulses++;
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL start_repress_count got %0d want 1", pulses);
        end
        btn_in = 4'b0000;
    endtask

    task automatic test_glitch;
        quiesce();
        btn_in = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        btn_in = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if (controller_out !== 4'b0000 || exp_out !== 4'b0000) begin
                miscompares++;
                $display("FAIL glitch i=%0d got %b model %b want 0000", i, controller_out, exp_out);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] want;
        quiesce();
        btn_in = 4'b1101;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == DEB + 2) want = 4'b0100;
            else if (i >= DEB + 2 + RD && (i - DEB - 2 - RD) % RR == 0) want = 4'b1000;
            else want = 4'b0000;
            vectors++;
            if (controller_out !== want || controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL simultaneous i=%0d got %b want %b model %b", i, controller_out, want, exp_out);
            end
        end
        btn_in = 4'b0000;
    endtask

    task automatic test_reset_mid;
        logic [3:0] want;
        quiesce();
        btn_in = 4'b1000;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (controller_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_edge got %b want 0000", controller_out);
        end
        for (int i = 1; i <= 24; i++) begin
            tick();
            want = (i == DEB + 3 || (i >= DEB + 3 + RD && (i - DEB - 3 - RD) % RR == 0))
                   ? 4'b1000 : 4'b0000;
            vectors++;
            if (controller_out !== want || controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL reset_mid i=%0d got %b want %b model %b", i, controller_out, want, exp_out);
            end
        end
        btn_in = 4'b0000;
    endtask

    task automatic test_glitch_in_repeat;
        logic [3:0] want;
        quiesce();
        btn_in = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            tick();
            btn_in = (i == 19 || i == 20) ? 4'b0000 : 4'b0010;
            want = (i == DEB + 2 || (i >= DEB + 2 + RD && (i - DEB - 2 - RD) % RR == 0))
                   ? 4'b0010 : 4'b0000;
            vectors++;
            if (controller_out !== want || controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL glitch_repeat i=%0d got %b want %b model %b", i, controller_out, want, exp_out);
            end
        end
        btn_in = 4'b0000;
    endtask

    task automatic test_random;
        logic [3:0] prev;
        logic [3:0] level;
        quiesce();
        prev = 4'b0000;
        level = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 24) == 0) level[b] = ~level[b];
            btn_in = level;
            if ($urandom_range(0, 15) == 0) btn_in[$urandom_range(0, 3)] ^= 1'b1;
            reset = ($urandom_range(0, 299) == 0);
            tick();
            vectors++;
            if (controller_out !== exp_out) begin
                miscompares++;
                $display("FAIL random i=%0d got %b want %b", i, controller_out, exp_out);
            end
            if ((controller_out & (controller_out - 4'd1)) != 4'b0000 ||
                (controller_out & prev) != 4'b0000) begin
                vectors++;
                miscompares++;
                $display("FAIL random_shape i=%0d got %b prev %b", i, controller_out, prev);
            end
            prev = controller_out;
        end
        reset = 1'b0;
        btn_in = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_repeat_bit0();
        test_start_no_repeat();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_glitch_in_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
